instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction-fetch unit for the RV32I pipelined processor. It is the initiator on the instruction-memory port: it drives a byte PC to a single-cycle-latency instruction memory and buffers returned words in a 2-entry queue. It presents {pc, instr} pairs to decode over a valid/ready handshake. A redirect from execute (branch/jump) flushes everything in flight and restarts fetch at the target.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched first after reset release
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous, active-low reset
- redirect_valid  in  1  flush and restart fetch this cycle
- redirect_target  in  32  new PC; bits [1:0] ignored and forced to 0
- imem_req  out  1  fetch request; the memory always accepts
- imem_addr  out  32  byte address of the request, word aligned
- imem_rdata  in  32  instruction word for the request issued on the previous cycle
- id_valid  out  1  queue head valid toward decode
- id_pc  out  32  PC of the head instruction
- id_instr  out  32  head instruction word
- id_ready  in  1  decode accepts the head this cycle

## Operation
- State:
  - fetch_pc (32b)
  - inflight flag plus inflight_pc (32b)
  - 2-entry FIFO of {pc, instr}, with count 0..2
- pop = id_valid & id_ready.
- Issue rule:
  - imem_req = !redirect_valid & (count + inflight - pop < 2).
  - Combinational from registered state and inputs.
- On issue:
  - inflight <= 1, inflight_pc <= fetch_pc, fetch_pc <= fetch_pc + 4 (mod 2^32, wraps to 0).
  - With no issue, inflight <= 0.
- Response: when inflight = 1 and there is no redirect this cycle, push {inflight_pc, imem_rdata} at the clock edge. The credit rule guarantees the FIFO never overflows.
- Redirect (redirect_valid = 1):
  - A decode handshake in the same cycle still completes; that entry counts as consumed.
  - At the edge: FIFO cleared (count <= 0), inflight <= 0, the in-flight response is discarded, and fetch_pc <= {redirect_target[31:2], 2'b00}.
  - imem_req = 0 in the redirect cycle. The target is requested on the next cycle.
  - Back-to-back redirects: the last one wins, and no request is issued on any redirect cycle.
- Push and pop in the same cycle: count is unchanged and order is preserved (FIFO).
- id_valid = (count != 0). id_pc and id_instr show the head entry and hold stable while id_valid & !id_ready.
- When count = 0, id_pc and id_instr hold their last values; these are don't-care for checking.

## Timing
- Reset (resetn low, asynchronous):
  - Registers: fetch_pc = RESET_PC, inflight = 0, count = 0.
  - Outputs: imem_req = 0 while reset is asserted, imem_addr = RESET_PC, id_valid = 0, id_pc = 0, id_instr = 0.
- Reset asserted mid-operation drops all queued and in-flight state immediately. No response is pushed afterwards.
- First edge after release (cycle 0): imem_req = 1, imem_addr = RESET_PC.
- Request at cycle N → imem_rdata sampled at the end of cycle N+1 → id_valid at cycle N+2. Fetch-to-decode latency is 2 cycles.
- Sustained throughput with id_ready held high is one instruction per cycle.
- Stall (id_ready = 0):
  - At most 2 queued entries plus 0 in flight.
  - imem_req falls to 0 within 1 cycle of count + inflight reaching 2.
  - Requests resume in the same cycle that a pop frees a credit.
- Redirect at cycle R:
  - Target requested at R+1.
  - First target instruction has id_valid at R+3.
  - No stale (pre-redirect) entry appears on id_valid after cycle R.

## Test plan
Memory model: imem_rdata = 32'hA000_0000 | previous-cycle imem_addr.

- Reset release with RESET_PC = 0 and id_ready = 1:
  - imem_addr sequence is 0, 4, 8, … one per cycle.
  - id_valid first at cycle 2 with id_pc = 0, id_instr = 32'hA000_0000.
  - Then consecutive PCs every cycle, with no bubbles.
- id_ready = 0 from cycle 2 for 5 cycles:
  - imem_req drops after 2 outstanding requests.
  - id_pc holds 0 with id_instr stable.
  - On release, pops deliver 0, 4, 8 in order, with no duplicates or gaps.
- redirect_valid pulse at cycle 6 with target 32'h0000_0080:
  - imem_req = 0 at cycle 6, imem_addr = 32'h80 at cycle 7.
  - No id_pc outside {≤ pre-redirect pops} appears after cycle 6.
  - Next id_pc = 32'h80 at cycle 9.
- Redirect concurrent with a pop while stalled (count = 2), target 32'h0000_0103:
  - The popped entry is accepted and the queue empties.
  - Fetch restarts at 32'h100.
- Wrap-around with RESET_PC = 32'hFFFF_FFFC:
  - id_pc sequence is FFFF_FFFC then 0000_0000.
- resetn asserted mid-stream with 2 entries queued:
  - id_valid = 0 and imem_req = 0 immediately (asynchronous).
  - After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Instruction-fetch bundle: imem request/response, decode handshake and
// the execute-stage redirect.
// master = fetch unit, slave = environment (memory, decode, execute).
interface instr_fetch_if;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        id_ready;

    modport master (
        input  redirect_valid, redirect_target, imem_rdata, id_ready,
        output imem_req, imem_addr, id_valid, id_pc, id_instr
    );

    modport slave (
        output redirect_valid, redirect_target, imem_rdata, id_ready,
        input  imem_req, imem_addr, id_valid, id_pc, id_instr
    );
endinterface

// File: rtl/instr_fetch.sv
// RV32I instruction-fetch unit.
// Issues word-aligned PCs to a single-cycle instruction memory.
// Queues returned words in a 2-entry FIFO toward decode.
// A redirect flushes the queue and the in-flight response.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          resetn,
    instr_fetch_if.master bus
);

    logic [31:0] fetch_pc;
    logic        inflight;
    logic [31:0] inflight_pc;

    logic [31:0] q_pc    [2];
    logic [31:0] q_instr [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;

    logic        pop;
    logic        push;
    logic        issue;
    logic [2:0]  credit_used;
    logic [31:0] target_aligned;

    // A pop only happens with a non-empty queue, so credit_used cannot underflow.
    assign pop            = (count != 2'd0) & bus.id_ready;
    assign push           = inflight & ~bus.redirect_valid;
    assign credit_used    = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    // Gating with resetn holds the request low while reset is asserted.
    assign issue          = resetn & ~bus.redirect_valid & (credit_used < 3'd2);
    assign target_aligned = bus.redirect_target & ~32'h0000_0003;

    assign bus.imem_req  = issue;
    assign bus.imem_addr = fetch_pc;
    assign bus.id_valid  = (count != 2'd0);
    assign bus.id_pc     = q_pc[rd_ptr];
    assign bus.id_instr  = q_instr[rd_ptr];

    // PC sequencing and the in-flight tracker; a redirect discards the pending response.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= 32'h0000_0000;
        end else if (bus.redirect_valid) begin
            fetch_pc <= target_aligned;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + 32'd4;
            end
        end
    end

    // Two-entry response queue; a redirect empties it after any same-cycle pop.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q_pc[0]    <= 32'h0000_0000;
            q_pc[1]    <= 32'h0000_0000;
            q_instr[0] <= 32'h0000_0000;
            q_instr[1] <= 32'h0000_0000;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            count      <= 2'd0;
        end else if (bus.redirect_valid) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                q_pc[wr_ptr]    <= inflight_pc;
                q_instr[wr_ptr] <= bus.imem_rdata;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: per-cycle vector table plus hand-written
// sequences for redirect-while-stalled, PC wrap-around and mid-stream reset.
module tb_instr_fetch;

    localparam bit Y = 1'b1;
    localparam bit N = 1'b0;

    logic clk = 1'b0;
    logic resetn;

    always #5 clk = ~clk;

    instr_fetch_if bus ();
    instr_fetch_if wbus ();

    instr_fetch #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.master)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk    (clk),
        .resetn (resetn),
        .bus    (wbus.master)
    );

    // Memory model: returns A000_0000 | address requested on the previous cycle.
    logic [31:0] prev_addr;
    logic [31:0] wprev_addr;
    always @(posedge clk) begin
        prev_addr  <= bus.imem_addr;
        wprev_addr <= wbus.imem_addr;
    end
    assign bus.imem_rdata  = 32'hA000_0000 | prev_addr;
    assign wbus.imem_rdata = 32'hA000_0000 | wprev_addr;

    assign wbus.id_ready        = 1'b1;
    assign wbus.redirect_valid  = 1'b0;
    assign wbus.redirect_target = 32'h0000_0000;

    typedef struct {
        bit          rst;
        bit          ready;
        bit          rv;
        logic [31:0] tgt;
        bit          exp_req;
        logic [31:0] exp_addr;
        bit          exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input bit rst, input bit ready, input bit rv,
                                input logic [31:0] tgt, input bit req,
                                input logic [31:0] addr, input bit valid,
                                input logic [31:0] pc);
        vec_t v;
        v.rst       = rst;
        v.ready     = ready;
        v.rv        = rv;
        v.tgt       = tgt;
        v.exp_req   = req;
        v.exp_addr  = addr;
        v.exp_valid = valid;
        v.exp_pc    = pc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Leaves the bench just after a negedge with reset released: cycle 0.
    task automatic do_reset();
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = 32'h0000_0000;
        bus.id_ready        = 1'b1;
        resetn              = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        // Scenario A: streaming, then id_ready low for cycles 2..6.
        vecs.push_back(mk(Y, Y, N, 32'h0, Y, 32'h00, N, 32'h00));
        vecs.push_back(mk(N, Y, N, 32'h0, Y, 32'h04, N, 32'h00));
        vecs.push_back(mk(N, N, N, 32'h0, N, 32'h08, Y, 32'h00));
        for (int k = 3; k <= 6; k++)
            vecs.push_back(mk(N, N, N, 32'h0, N, 32'h08, Y, 32'h00));
        vecs.push_back(mk(N, Y, N, 32'h0, Y, 32'h08, Y, 32'h00));
        vecs.push_back(mk(N, Y, N, 32'h0, Y, 32'h0C, Y, 32'h04));
        vecs.push_back(mk(N, Y, N, 32'h0, Y, 32'h10, Y, 32'h08));
        vecs.push_back(mk(N, Y, N, 32'h0, Y, 32'h14, Y, 32'h0C));
        // Scenario B: streaming with a redirect to 0x80 at cycle 6.
        vecs.push_back(mk(Y, Y, N, 32'h0, Y, 32'h00, N, 32'h00));
        vecs.push_back(mk(N, Y, N, 32'h0, Y, 32'h04, N, 32'h00));
        vecs.push_back(mk(N, Y, N, 32'h0, Y, 32'h08, Y, 32'h00));
        vecs.push_back(mk(N, Y, N, 32'h0, Y, 32'h0C, Y, 32'h04));
        vecs.push_back(mk(N, Y, N, 32'h0, Y, 32'h10, Y, 32'h08));
        vecs.push_back(mk(N, Y, N, 32'h0, Y, 32'h14, Y, 32'h0C));
        vecs.push_back(mk(N, Y, Y, 32'h80, N, 32'h00, Y, 32'h10));
        vecs.push_back(mk(N, Y, N, 32'h0, Y, 32'h80, N, 32'h00));
        vecs.push_back(mk(N, Y, N, 32'h0, Y, 32'h84, N, 32'h00));
        vecs.push_back(mk(N, Y, N, 32'h0, Y, 32'h88, Y, 32'h80));
        vecs.push_back(mk(N, Y, N, 32'h0, Y, 32'h8C, Y, 32'h84));

        // Values while reset is held.
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = 32'h0000_0000;
        bus.id_ready        = 1'b1;
        resetn              = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst imem_req",  {31'b0, bus.imem_req}, 32'h0);
        check("rst imem_addr", bus.imem_addr, 32'h0);
        check("rst id_valid",  {31'b0, bus.id_valid}, 32'h0);
        check("rst id_pc",     bus.id_pc, 32'h0);
        check("rst id_instr",  bus.id_instr, 32'h0);
        check("rst wrap addr", wbus.imem_addr, 32'hFFFF_FFFC);

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            else @(negedge clk);
            bus.id_ready        = vecs[i].ready;
            bus.redirect_valid  = vecs[i].rv;
            bus.redirect_target = vecs[i].tgt;
            #1;
            check($sformatf("vec%0d imem_req", i), {31'b0, bus.imem_req}, {31'b0, vecs[i].exp_req});
            if (vecs[i].exp_req)
                check($sformatf("vec%0d imem_addr", i), bus.imem_addr, vecs[i].exp_addr);
            check($sformatf("vec%0d id_valid", i), {31'b0, bus.id_valid}, {31'b0, vecs[i].exp_valid});
            if (vecs[i].exp_valid) begin
                check($sformatf("vec%0d id_pc", i), bus.id_pc, vecs[i].exp_pc);
                check($sformatf("vec%0d id_instr", i), bus.id_instr, 32'hA000_0000 | vecs[i].exp_pc);
            end
        end
        bus.redirect_valid = 1'b0;

        // Redirect to 0x103 together with a pop while the queue is full.
        do_reset();
        @(negedge clk);
        @(negedge clk);
        bus.id_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.id_ready        = 1'b1;
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h0000_0103;
        #1;
        check("rdp pop valid", {31'b0, bus.id_valid}, 32'h1);
        check("rdp pop pc",    bus.id_pc, 32'h0);
        check("rdp req low",   {31'b0, bus.imem_req}, 32'h0);
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        #1;
        check("rdp empty",     {31'b0, bus.id_valid}, 32'h0);
        check("rdp req",       {31'b0, bus.imem_req}, 32'h1);
        check("rdp addr",      bus.imem_addr, 32'h100);
        @(negedge clk);
        #1;
        check("rdp addr2",     bus.imem_addr, 32'h104);
        check("rdp empty2",    {31'b0, bus.id_valid}, 32'h0);
        @(negedge clk);
        #1;
        check("rdp tgt valid", {31'b0, bus.id_valid}, 32'h1);
        check("rdp tgt pc",    bus.id_pc, 32'h100);
        check("rdp tgt instr", bus.id_instr, 32'hA000_0100);

        // PC wrap-around on the second instance.
        do_reset();
        #1;
        check("wrap req0",  {31'b0, wbus.imem_req}, 32'h1);
        check("wrap addr0", wbus.imem_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        #1;
        check("wrap addr1", wbus.imem_addr, 32'h0);
        @(negedge clk);
        #1;
        check("wrap valid2", {31'b0, wbus.id_valid}, 32'h1);
        check("wrap pc2",    wbus.id_pc, 32'hFFFF_FFFC);
        check("wrap instr2", wbus.id_instr, 32'hFFFF_FFFC);
        @(negedge clk);
        #1;
        check("wrap pc3",    wbus.id_pc, 32'h0);
        check("wrap instr3", wbus.id_instr, 32'hA000_0000);

        // Asynchronous reset with two entries queued.
        do_reset();
        @(negedge clk);
        @(negedge clk);
        bus.id_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("mrst full valid", {31'b0, bus.id_valid}, 32'h1);
        check("mrst full req",   {31'b0, bus.imem_req}, 32'h0);
        #2;
        resetn = 1'b0;
        #1;
        check("mrst valid", {31'b0, bus.id_valid}, 32'h0);
        check("mrst req",   {31'b0, bus.imem_req}, 32'h0);
        check("mrst pc",    bus.id_pc, 32'h0);
        @(negedge clk);
        resetn       = 1'b1;
        bus.id_ready = 1'b1;
        #1;
        check("mrst c0 req",  {31'b0, bus.imem_req}, 32'h1);
        check("mrst c0 addr", bus.imem_addr, 32'h0);
        @(negedge clk);
        #1;
        check("mrst c1 valid", {31'b0, bus.id_valid}, 32'h0);
        @(negedge clk);
        #1;
        check("mrst c2 valid", {31'b0, bus.id_valid}, 32'h1);
        check("mrst c2 pc",    bus.id_pc, 32'h0);
        check("mrst c2 instr", bus.id_instr, 32'hA000_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
